// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock.
// Divide-by-zero completes immediately with all-ones quotient.
module restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   partial;
    logic [WIDTH-1:0] dvd_sr;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] q_sr;

    logic             accept;
    logic             last;
    logic             qbit;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   p_next;
    logic [WIDTH-1:0] q_next;

    assign ready   = (state == IDLE) || (state == DONE);
    assign accept  = ready && start;
    assign last    = (count == CW'(WIDTH - 1));

    assign shifted = {partial[WIDTH-1:0], dvd_sr[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs};
    assign qbit    = ~trial[WIDTH];
    assign p_next  = qbit ? trial : shifted;
    assign q_next  = (q_sr << 1) | WIDTH'(qbit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_n = (divisor == '0) ? DONE : RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                if (last) begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Result registers move only on a completion edge; they hold through RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            done        <= 1'b0;
            count       <= '0;
            partial     <= '0;
            dvd_sr      <= '0;
            dvs         <= '0;
            q_sr        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= (state_n == DONE);
            if (accept) begin
                count   <= '0;
                partial <= '0;
                q_sr    <= '0;
                dvd_sr  <= dividend;
                dvs     <= divisor;
                if (divisor == '0) begin
                    quotient    <= '1;
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                end
            end else if (state == RUN) begin
                count   <= count + CW'(1);
                partial <= p_next;
                dvd_sr  <= dvd_sr << 1;
                q_sr    <= q_next;
                if (last) begin
                    quotient    <= q_next;
                    remainder   <= p_next[WIDTH-1:0];
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Randomized self-checking bench for restoring_divider.
// Expected results come from plain / and % arithmetic.
module tb_restoring_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         ready;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] m_q = '0;
    logic [W-1:0] m_r = '0;
    logic         m_z = 1'b0;

    restoring_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .ready      (ready),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag);
        chk({tag, ".q"}, 32'(quotient), 32'(m_q));
        chk({tag, ".r"}, 32'(remainder), 32'(m_r));
        chk({tag, ".z"}, 32'(div_by_zero), 32'(m_z));
    endtask

    // Starts a/b on the next edge (edge 0) and follows it to done.
    // noise drives a competing start with 50/5 on edges 3..6.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit noise);
        int           lat;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        lat = (b == '0) ? 0 : W;
        if (b == '0) begin
            eq = '1;
            er = a;
            ez = 1'b1;
        end else begin
            eq = a / b;
            er = a % b;
            ez = 1'b0;
        end
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        for (int k = 0; k <= lat; k++) begin
            tick();
            if (k < lat) begin
                chk("run.done", 32'(done), 32'd0);
                chk("run.ready", 32'(ready), 32'd0);
                chk_out("run.hold");
            end else begin
                m_q = eq;
                m_r = er;
                m_z = ez;
                chk("fin.done", 32'(done), 32'd1);
                chk("fin.ready", 32'(ready), 32'd1);
                chk_out("fin");
            end
            start = noise && (k >= 2) && (k <= 5);
            if (start) begin
                dividend = 8'd50;
                divisor  = 8'd5;
            end else begin
                dividend = W'($urandom);
                divisor  = W'($urandom);
            end
        end
        start = 1'b0;
    endtask

    task automatic idle;
        start = 1'b0;
        tick();
        chk("idle.done", 32'(done), 32'd0);
        chk("idle.ready", 32'(ready), 32'd1);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           b2b;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        start = 1'b1;
        tick();
        chk("rst.ready", 32'(ready), 32'd1);
        chk("rst.done", 32'(done), 32'd0);
        chk_out("rst");
        start = 1'b0;
        rst   = 1'b0;

        do_div(8'd100, 8'd7, 1'b0);
        idle();
        do_div(8'd255, 8'd1, 1'b0);
        idle();
        do_div(8'd5, 8'd9, 1'b0);
        idle();
        do_div(8'd255, 8'd255, 1'b0);
        idle();
        do_div(8'd77, 8'd0, 1'b0);
        idle();

        do_div(8'd100, 8'd7, 1'b1);
        idle();

        do_div(8'd100, 8'd7, 1'b0);
        do_div(8'd200, 8'd3, 1'b0);
        idle();

        do_div(8'd10, 8'd3, 1'b0);
        idle();
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        m_q = '0;
        m_r = '0;
        m_z = 1'b0;
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.ready", 32'(ready), 32'd1);
        chk_out("abort");
        rst = 1'b0;
        do_div(8'd9, 8'd2, 1'b0);
        idle();

        repeat (40) begin
            a   = W'($urandom);
            b   = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            b2b = ($urandom_range(0, 3) == 0);
            do_div(a, b, 1'b0);
            if (!b2b) begin
                idle();
            end
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand, quotient and remainder width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a division, sampled only when ready=1.
REQ-005 The block SHALL have port dividend, input, WIDTH bits: unsigned numerator, captured on the accepting edge.
REQ-006 The block SHALL have port divisor, input, WIDTH bits: unsigned denominator, captured on the accepting edge.
REQ-007 The block SHALL have port ready, output, 1 bit: high when a start will be accepted (state IDLE or DONE).
REQ-008 The block SHALL have port done, output, 1 bit: high for exactly one cycle, in the DONE state.
REQ-009 The block SHALL have port quotient, output, WIDTH bits: result of the last completed division.
REQ-010 The block SHALL have port remainder, output, WIDTH bits: remainder of the last completed division.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: high when the last completed division had divisor=0.

Function
REQ-012 The block SHALL implement the states IDLE, RUN and DONE, encoded internally.
REQ-013 On an edge with ready=1 and start=1, the block SHALL capture dividend and divisor and take the next state by divisor: nonzero -> RUN with iteration count 0 and partial remainder 0; zero -> DONE.
REQ-014 In RUN, each edge SHALL perform one restoring step.
- Shift the (WIDTH+1)-bit partial remainder left by one, inserting the dividend shift-register MSB.
- Form trial = partial - divisor at WIDTH+1 bits.
- If trial is non-negative (MSB=0): partial = trial; shift quotient bit 1 into the quotient shift register.
- Otherwise: keep the shifted partial; shift in 0.
REQ-015 After exactly WIDTH RUN edges, the block SHALL go to DONE and load quotient, remainder (low WIDTH bits of partial) and div_by_zero=0 into the output registers on that same edge.
REQ-016 For divisor=0, the DONE-entry edge SHALL load quotient=all ones, remainder=captured dividend and div_by_zero=1.
REQ-017 Latency SHALL be as follows, counting the accepting edge as edge 0.
- Nonzero divisor: done high in the cycle after edge WIDTH.
- Zero divisor: done high in the cycle after edge 0.
REQ-018 DONE SHALL last one cycle; the next state is RUN or DONE per REQ-013 if start=1, else IDLE.
REQ-019 start while in RUN SHALL be ignored, with no effect on state, captured operands or outputs.
REQ-020 quotient, remainder and div_by_zero SHALL change only on a completion edge or reset, and hold otherwise, including throughout RUN.
REQ-021 Changes on dividend and divisor after the accepting edge SHALL NOT affect the result in progress.
REQ-022 done SHALL be registered, not decoded combinationally from start.

Reset
REQ-023 An edge with rst=1 SHALL force state IDLE, ready=1, done=0, quotient=0, remainder=0 and div_by_zero=0, and clear the iteration count and internal registers.
REQ-024 rst SHALL take priority over start and over an in-progress division; an aborted division SHALL produce no done pulse.
REQ-025 start SHALL be accepted on the first edge after rst returns low.

Verification
REQ-026 The bench SHALL cover WIDTH=8, dividend=100, divisor=7, start at edge 0 -> done in the cycle after edge 8, quotient=14, remainder=2, div_by_zero=0, ready=0 during RUN.
REQ-027 The bench SHALL cover boundary values.
- 255/1 -> quotient=255, remainder=0.
- 5/9 -> quotient=0, remainder=5.
- 255/255 -> quotient=1, remainder=0.
REQ-028 The bench SHALL cover dividend=77, divisor=0 -> done in the cycle after edge 0, quotient=255, remainder=77, div_by_zero=1.
REQ-029 The bench SHALL cover 100/7 started, then start=1 with 50/5 on edges 3..6 -> ignored; result 14 r 2; outputs unchanged until completion.
REQ-030 The bench SHALL cover back-to-back operations: start=1 during DONE of 100/7 with 200/3 -> second done 9 cycles after the first; quotient=66, remainder=2.
REQ-031 The bench SHALL cover rst=1 at edge 4 of 100/7 (after a prior result) -> no done pulse, all outputs 0, ready=1; a new 9/2 then gives quotient=4, remainder=1.
